// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: pointer increment with explicit
// wrap (no power-of-two assumption) and width helpers for count/pointers.
package fifo_pkg;

  // Advance a pointer by one, wrapping depth-1 -> 0.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Width of an occupancy counter that must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer addressing 0..depth-1, never less than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Flop-based storage for the FIFO: depth x bits array, one synchronous write
// port and one asynchronous (combinational) read port.
module fifo_mem #(
  parameter int bits   = 32,
  parameter int depth  = 16,
  parameter int addr_w = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [bits-1:0]   wdata,
  input  logic [addr_w-1:0] raddr,
  output logic [bits-1:0]   rdata
);

  logic [bits-1:0] mem [depth];

  // Write the addressed entry when a push is accepted.
  // NOTE: storage has no reset; validity is tracked by count/pointers, so
  // resetting the array would only cost flops with reset pins for no benefit.
  // NOTE: non-blocking (<=) for every clocked assignment so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param_flags.sv
// Parametrised flop-based synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty flags and defined push+pop at every boundary.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN
// is defined; otherwise both outputs are tied to 0.
module fifo_param_flags
  import fifo_pkg::*;
#(
  parameter int bits      = 32,
  parameter int depth     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [bits-1:0]           Din,
  input  logic                      push,
  input  logic                      pop,
  output logic [bits-1:0]           Dout,
  output logic                      full,
  output logic                      pndng,
  output logic [cnt_w(depth)-1:0]   count,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CNT_W = cnt_w(depth);
  localparam int PTR_W = ptr_w(depth);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_inc, rd_ptr_inc;
  logic [CNT_W-1:0] count_next;
  logic [bits-1:0]  rdata;
  logic             push_ok, pop_ok;

  // Flags are pure functions of the registered count.
  assign full         = (count == CNT_W'(depth));
  assign pndng        = (count != '0);
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));

  // A pop frees a slot, so a push into a full FIFO is fine alongside a pop;
  // a pop on an empty FIFO is always refused, even with a concurrent push.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & pndng;

  assign wr_ptr_inc = PTR_W'(ptr_inc(32'(wr_ptr), depth));
  assign rd_ptr_inc = PTR_W'(ptr_inc(32'(rd_ptr), depth));

  // Next occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
  // NOTE: count_next gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)      count_next = count + CNT_W'(1);
    else if (!push_ok && pop_ok) count_next = count - CNT_W'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr_inc;
      if (pop_ok)  rd_ptr <= rd_ptr_inc;
      count <= count_next;
    end
  end

  fifo_mem #(
    .bits   (bits),
    .depth  (depth),
    .addr_w (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (Din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Show-ahead head; forced to zero when nothing is pending.
  assign Dout = pndng ? rdata : '0;

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop) overflow  <= 1'b1;
      if (pop && !pndng)        underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param_flags.sv
// Directed testbench for fifo_param_flags: a depth-16 instance driven from a
// table of {inputs, expected state} records, and a depth-5 instance exercised
// by hand-written wrap sequences. Error-flag expectations follow
// FIFO_ERR_FLAGS_EN.
module tb_fifo_param_flags;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // depth-16 instance
  logic [31:0] din16 = '0, dout16;
  logic        push16 = 1'b0, pop16 = 1'b0;
  logic        full16, pndng16, af16, ae16, ovf16, udf16;
  logic [4:0]  count16;

  fifo_param_flags #(.bits(32), .depth(16), .AF_THRESH(14), .AE_THRESH(2)) dut16 (
    .clk(clk), .rst(rst), .Din(din16), .push(push16), .pop(pop16),
    .Dout(dout16), .full(full16), .pndng(pndng16), .count(count16),
    .almost_full(af16), .almost_empty(ae16), .overflow(ovf16), .underflow(udf16)
  );

  // depth-5 instance
  logic [7:0]  din5 = '0, dout5;
  logic        push5 = 1'b0, pop5 = 1'b0;
  logic        full5, pndng5, af5, ae5, ovf5, udf5;
  logic [2:0]  count5;

  fifo_param_flags #(.bits(8), .depth(5), .AF_THRESH(4), .AE_THRESH(1)) dut5 (
    .clk(clk), .rst(rst), .Din(din5), .push(push5), .pop(pop5),
    .Dout(dout5), .full(full5), .pndng(pndng5), .count(count5),
    .almost_full(af5), .almost_empty(ae5), .overflow(ovf5), .underflow(udf5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One record: inputs for a cycle and the state expected after its edge.
  typedef struct {
    logic        push;
    logic        pop;
    logic [31:0] din;
    int          cnt;
    logic [31:0] dout;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic p, input logic q, input logic [31:0] d,
                         input int c, input logic [31:0] o,
                         input logic ov, input logic un);
    vec_t v;
    v.push = p; v.pop = q; v.din = d; v.cnt = c; v.dout = o; v.ovf = ov; v.udf = un;
    vecs.push_back(v);
  endtask

  task automatic check16_reset(input string tag);
    check({tag, " count"}, 32'(count16), 0);
    check({tag, " full"},  32'(full16),  0);
    check({tag, " pndng"}, 32'(pndng16), 0);
    check({tag, " af"},    32'(af16),    0);
    check({tag, " ae"},    32'(ae16),    1);
    check({tag, " ovf"},   32'(ovf16),   0);
    check({tag, " udf"},   32'(udf16),   0);
    check({tag, " dout"},  dout16,       0);
  endtask

  initial begin
    // Build the depth-16 table.
    for (int i = 0; i < 16; i++) add_vec(1, 0, 32'(i), i + 1, 0, 0, 0);      // fill
    add_vec(1, 0, 32'h11, 16, 0, ERR, 0);                                      // 17th push dropped
    for (int k = 0; k < 16; k++)                                               // drain in order
      add_vec(0, 1, 0, 15 - k, (k < 15) ? 32'(k + 1) : 32'h0, ERR, 0);
    for (int i = 0; i < 16; i++) add_vec(1, 0, 32'(i), i + 1, 0, ERR, 0);    // refill
    add_vec(1, 1, 32'hAA, 16, 32'h1, ERR, 0);                                  // full push+pop
    for (int j = 1; j <= 16; j++)
      add_vec(0, 1, 0, 16 - j,
              (j < 15) ? 32'(j + 1) : ((j == 15) ? 32'hAA : 32'h0), ERR, 0);
    add_vec(1, 1, 32'h55, 1, 32'h55, ERR, ERR);                                // empty push+pop
    add_vec(0, 1, 0, 0, 0, ERR, ERR);
    add_vec(0, 0, 0, 0, 0, ERR, ERR);

    // Initial reset, then put some data in so the mid-cycle reset discards it.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push16 = 1'b1; din16 = 32'hDEAD;
    repeat (2) @(negedge clk);
    push16 = 1'b0;
    check("pre-reset count", 32'(count16), 2);
    @(posedge clk); #2 rst = 1'b1;
    #1 check16_reset("async reset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check16_reset("after release");

    // Table-driven depth-16 run.
    for (int i = 0; i < vecs.size(); i++) begin
      push16 = vecs[i].push; pop16 = vecs[i].pop; din16 = vecs[i].din;
      @(negedge clk);
      check($sformatf("v%0d count", i), 32'(count16), vecs[i].cnt);
      check($sformatf("v%0d dout", i),  dout16,       vecs[i].dout);
      check($sformatf("v%0d full", i),  32'(full16),  32'(vecs[i].cnt == 16));
      check($sformatf("v%0d pndng", i), 32'(pndng16), 32'(vecs[i].cnt != 0));
      check($sformatf("v%0d af", i),    32'(af16),    32'(vecs[i].cnt >= 14));
      check($sformatf("v%0d ae", i),    32'(ae16),    32'(vecs[i].cnt <= 2));
      check($sformatf("v%0d ovf", i),   32'(ovf16),   32'(vecs[i].ovf));
      check($sformatf("v%0d udf", i),   32'(udf16),   32'(vecs[i].udf));
    end
    push16 = 1'b0; pop16 = 1'b0;

    // depth-5: prefill 0x30..0x32.
    for (int i = 0; i < 3; i++) begin
      push5 = 1'b1; din5 = 8'(8'h30 + i);
      @(negedge clk);
    end
    check("d5 prefill count", 32'(count5), 3);
    check("d5 prefill ae", 32'(ae5), 0);
    // 12 simultaneous push/pop cycles: pointers wrap several times.
    for (int k = 0; k < 12; k++) begin
      check($sformatf("d5 head %0d", k), 32'(dout5), 32'(8'h30 + k));
      push5 = 1'b1; pop5 = 1'b1; din5 = 8'(8'h33 + k);
      @(negedge clk);
      check($sformatf("d5 count %0d", k), 32'(count5), 3);
    end
    // Top up to full.
    pop5 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din5 = 8'(8'h3F + i);
      @(negedge clk);
    end
    push5 = 1'b0;
    check("d5 full", 32'(full5), 1);
    check("d5 count full", 32'(count5), 5);
    check("d5 af", 32'(af5), 1);
    // Drain: 0x3C..0x40 in order.
    for (int k = 0; k < 5; k++) begin
      check($sformatf("d5 drain %0d", k), 32'(dout5), 32'(8'h3C + k));
      pop5 = 1'b1;
      @(negedge clk);
    end
    pop5 = 1'b0;
    check("d5 empty pndng", 32'(pndng5), 0);
    check("d5 empty dout", 32'(dout5), 0);
    check("d5 ae", 32'(ae5), 1);

    // Mid-operation reset clears data and sticky flags.
    push16 = 1'b1; din16 = 32'h77;
    @(negedge clk);
    push16 = 1'b0;
    check("pre-reset2 count", 32'(count16), 1);
    @(posedge clk); #3 rst = 1'b1;
    #1 check16_reset("reset2");
    @(negedge clk); rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
